// File: rtl/step_scheduler_if.sv
// Command channel of the step scheduler: a move request (step count and
// inter-step gap) offered by the host under a valid/ready handshake.
interface step_scheduler_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 16
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [CNT_W-1:0] CMD_COUNT;
  logic [GAP_W-1:0] CMD_GAP;

  // Host side: offers commands and watches READY.
  modport master (
    output CMD_VALID,
    output CMD_COUNT,
    output CMD_GAP,
    input  CMD_READY
  );

  // Scheduler side: accepts commands.
  modport slave (
    input  CMD_VALID,
    input  CMD_COUNT,
    input  CMD_GAP,
    output CMD_READY
  );
endinterface

// File: rtl/step_scheduler.sv
// Step scheduler: turns one accepted move command into a train of
// PULSE_LEN-wide STEP pulses separated by max(gap,1) low cycles, with
// abort support, a completion strobe and a live remaining-step count.
module step_scheduler #(
  parameter int CNT_W     = 16,
  parameter int GAP_W     = 16,
  parameter int PULSE_LEN = 1
) (
  input  logic             CLK,
  input  logic             RST,
  step_scheduler_if.slave  cmd,
  input  logic             ABORT,
  output logic             STEP,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORTED,
  output logic [CNT_W-1:0] REMAIN
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PULSE  = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int             PCW        = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_LEN - 1);

  logic [1:0]       state;
  logic [PCW-1:0]   pulse_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_eff;
  logic             abort_seen;

  logic             accept;
  logic             pulse_abort;
  logic [CNT_W-1:0] remain_dec;

  // Ready only while idle and out of reset, so reset blocks any handshake.
  assign cmd.CMD_READY = !BUSY && !RST;
  assign accept        = cmd.CMD_VALID && cmd.CMD_READY;
  // An abort seen in any cycle of the current pulse ends the move after it.
  assign pulse_abort   = abort_seen || ABORT;
  assign remain_dec    = REMAIN - CNT_W'(1);

  // Sequencer: state, counters and all registered outputs.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      STEP       <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ABORTED    <= 1'b0;
      REMAIN     <= '0;
      pulse_cnt  <= '0;
      gap_cnt    <= '0;
      gap_eff    <= GAP_W'(1);
      abort_seen <= 1'b0;
    end else begin
      // DONE/ABORTED are one-cycle strobes unless a branch below raises them.
      DONE    <= 1'b0;
      ABORTED <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            REMAIN     <= cmd.CMD_COUNT;
            gap_eff    <= (cmd.CMD_GAP == '0) ? GAP_W'(1) : cmd.CMD_GAP;
            BUSY       <= 1'b1;
            abort_seen <= 1'b0;
            pulse_cnt  <= '0;
            if (cmd.CMD_COUNT == '0) begin
              state <= S_FINISH;
              DONE  <= 1'b1;
            end else begin
              state <= S_PULSE;
              STEP  <= 1'b1;
            end
          end
        end

        S_PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            STEP   <= 1'b0;
            REMAIN <= remain_dec;
            if (remain_dec == '0 || pulse_abort) begin
              state   <= S_FINISH;
              DONE    <= 1'b1;
              ABORTED <= (remain_dec != '0);
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end else begin
            // The pulse always runs to full width; abort is only remembered.
            pulse_cnt  <= pulse_cnt + PCW'(1);
            abort_seen <= pulse_abort;
          end
        end

        S_GAP: begin
          if (ABORT) begin
            state   <= S_FINISH;
            DONE    <= 1'b1;
            ABORTED <= (REMAIN != '0);
          end else if (gap_cnt == gap_eff - GAP_W'(1)) begin
            state      <= S_PULSE;
            STEP       <= 1'b1;
            pulse_cnt  <= '0;
            abort_seen <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          STEP  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler: a per-cycle vector table (inputs plus
// expected registered outputs) applied to a PULSE_LEN=1 and a PULSE_LEN=3
// instance, followed by a hand-written long-move sequence.
module tb_step_scheduler;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] count;
  logic [15:0] gap;
  logic        abort;

  logic        step1, busy1, done1, aborted1;
  logic [15:0] remain1;
  logic        step3, busy3, done3, aborted3;
  logic [15:0] remain3;

  int n_cmp;
  int n_fail;

  step_scheduler_if #(.CNT_W(16), .GAP_W(16)) if1 ();
  step_scheduler_if #(.CNT_W(16), .GAP_W(16)) if3 ();

  assign if1.CMD_VALID = valid;
  assign if1.CMD_COUNT = count;
  assign if1.CMD_GAP   = gap;
  assign if3.CMD_VALID = valid;
  assign if3.CMD_COUNT = count;
  assign if3.CMD_GAP   = gap;

  step_scheduler #(.CNT_W(16), .GAP_W(16), .PULSE_LEN(1)) u_dut1 (
    .CLK(clk), .RST(rst), .cmd(if1), .ABORT(abort),
    .STEP(step1), .BUSY(busy1), .DONE(done1), .ABORTED(aborted1), .REMAIN(remain1)
  );

  step_scheduler #(.CNT_W(16), .GAP_W(16), .PULSE_LEN(3)) u_dut3 (
    .CLK(clk), .RST(rst), .cmd(if3), .ABORT(abort),
    .STEP(step3), .BUSY(busy3), .DONE(done3), .ABORTED(aborted3), .REMAIN(remain3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {STEP, BUSY, DONE, ABORTED, REMAIN[15:0], CMD_READY}.
  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] count;
    logic [15:0] gap;
    logic        abort;
    logic        sel;   // 0: PULSE_LEN=1 instance, 1: PULSE_LEN=3 instance
    logic        chk;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input int c, input int g,
                              input logic a, input logic s, input logic k,
                              input logic e_step, input logic e_busy, input logic e_done,
                              input logic e_ab, input int e_rem, input logic e_rdy);
    vec_t t;
    t.rst   = r;
    t.valid = v;
    t.count = 16'(c);
    t.gap   = 16'(g);
    t.abort = a;
    t.sel   = s;
    t.chk   = k;
    t.exp   = {e_step, e_busy, e_done, e_ab, 16'(e_rem), e_rdy};
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  logic [20:0] act;
  int          cyc;
  int          nsteps;
  int          done_cyc;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    valid  = 1'b0;
    count  = '0;
    gap    = '0;
    abort  = 1'b0;

    //  rst v  cnt gap ab sel chk | step busy done ab rem rdy
    // Reset holds off a waiting command; release then accept; reset mid-move.
    add(1, 1, 4, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(1, 1, 4, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    // COUNT=3 GAP=2: steps at 1,4,7; DONE at 8.
    add(0, 1, 3, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
    // COUNT=0: DONE in cycle 1, no STEP.
    add(0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
    // COUNT=2 GAP=0: one low cycle between steps.
    add(0, 1, 2, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
    // COUNT=5 GAP=2, ABORT in gap cycle 5.
    add(0, 1, 5, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 4, 0);
    add(0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 1, 3, 0);
    // VALID held: COUNT=1 GAP=5 (ABORT on the handshake is ignored), then COUNT=1.
    add(0, 1, 1, 5, 1, 0, 1,  0, 0, 0, 0, 3, 1);
    add(0, 1, 1, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    // PULSE_LEN=3 instance: ABORT mid-pulse, then a normal two-step move.
    add(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 1, 0, 1, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 5, 0);
    add(0, 0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 1, 4, 0);
    add(0, 1, 2, 1, 0, 1, 1,  0, 0, 0, 0, 4, 1);
    add(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 1, 1,  0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);

    // Each row is one cycle: drive inputs at the falling edge, check the
    // outputs visible during that cycle, and let the next rising edge act.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      valid = vecs[i].valid;
      count = vecs[i].count;
      gap   = vecs[i].gap;
      abort = vecs[i].abort;
      #1;
      if (vecs[i].sel)
        act = {step3, busy3, done3, aborted3, remain3, if3.CMD_READY};
      else
        act = {step1, busy1, done1, aborted1, remain1, if1.CMD_READY};
      if (vecs[i].chk)
        check($sformatf("vec[%0d] {step,busy,done,aborted,remain,ready}", i),
              32'(act), 32'(vecs[i].exp));
    end

    // Long move COUNT=4 GAP=3 on the PULSE_LEN=1 instance: steps at 1,5,9,13,
    // DONE at 14; the wait is bounded so a stuck DUT still reaches the summary.
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b1;
    count = 16'd4;
    gap   = 16'd3;
    cyc      = 0;
    nsteps   = 0;
    done_cyc = -1;
    while (cyc < 100 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      valid = 1'b0;
      #1;
      if (step1) nsteps++;
      if (done1) done_cyc = cyc;
    end
    check("long_move done_cycle", 32'(done_cyc), 32'd14);
    check("long_move step_count", 32'(nsteps), 32'd4);
    check("long_move remain_at_done", 32'(remain1), 32'd0);
    check("long_move aborted_at_done", 32'(aborted1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
